// File: rtl/catch_grid.sv
// catch_grid: player token on a 2^GRID_LOG2 square grid chasing an LFSR-placed target.
// Tracks catches, runs an IDLE/PLAY/WIN/LOSE game FSM with a per-catch move timeout.
// Optional build macro CATCH_GRID_WRAP_EN: coordinates wrap modulo the grid side at walls
// instead of saturating.
module catch_grid #(
  parameter int unsigned GRID_LOG2   = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned WIN_CATCHES = 15,
  parameter int unsigned MOVE_LIMIT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           yon,
  output logic [1:0]           durum,
  output logic [CNT_W-1:0]     yakalama_sayisi,
  output logic [GRID_LOG2-1:0] oyuncu_x,
  output logic [GRID_LOG2-1:0] oyuncu_y,
  output logic [GRID_LOG2-1:0] hedef_x,
  output logic [GRID_LOG2-1:0] hedef_y
);

  localparam logic [GRID_LOG2-1:0] CoordOne  = GRID_LOG2'(1);
  localparam logic [GRID_LOG2-1:0] CoordMax  = {GRID_LOG2{1'b1}};
  localparam logic [CNT_W-1:0]     WinCount  = CNT_W'(WIN_CATCHES);
  localparam logic [16:0]          TimeLimit = 17'(MOVE_LIMIT);
  localparam logic [7:0]           LfsrSeed  = 8'hA5;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StWin  = 2'b10,
    StLose = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GRID_LOG2-1:0] px_q, px_d, py_q, py_d;
  logic [GRID_LOG2-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [15:0]          timer_q, timer_d;

  // FSM output decode
  logic move_en;
  logic play_en;

  // Datapath results
  logic [GRID_LOG2-1:0] nx, ny;
  logic [GRID_LOG2-1:0] rx, ry;
  logic [CNT_W-1:0]     cnt_inc;
  logic [16:0]          timer_inc;
  logic                 catch_hit;
  logic                 win_hit;
  logic                 timeout;
  logic                 lfsr_fb;

  // One axis step: opposing or absent requests cancel; walls saturate or wrap.
  function automatic logic [GRID_LOG2-1:0] step_axis(input logic [GRID_LOG2-1:0] c,
                                                     input logic inc,
                                                     input logic dec);
    logic [GRID_LOG2-1:0] r;
    r = c;
    if (inc && !dec) begin
`ifdef CATCH_GRID_WRAP_EN
      r = c + CoordOne;
`else
      if (c != CoordMax) r = c + CoordOne;
`endif
    end else if (dec && !inc) begin
`ifdef CATCH_GRID_WRAP_EN
      r = c - CoordOne;
`else
      if (c != '0) r = c - CoordOne;
`endif
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a catch beats the timeout, and reaching the win count beats both
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (yon != 4'b0000) begin
          state_d = (catch_hit && win_hit) ? StWin : StPlay;
        end
      end
      StPlay: begin
        if (catch_hit) begin
          if (win_hit) state_d = StWin;
        end else if (timeout) begin
          state_d = StLose;
        end
      end
      StWin:  state_d = StWin;
      StLose: state_d = StLose;
      default: state_d = StIdle;
    endcase
  end

  // FSM output decode: the first non-zero direction in IDLE also moves the player
  always_comb begin
    move_en = 1'b0;
    play_en = 1'b0;
    unique case (state_q)
      StIdle: move_en = (yon != 4'b0000);
      StPlay: begin
        move_en = 1'b1;
        play_en = 1'b1;
      end
      default: begin
        move_en = 1'b0;
        play_en = 1'b0;
      end
    endcase
  end

  // Move, catch detection, respawn candidate and counters
  always_comb begin
    nx        = step_axis(px_q, yon[0], yon[1]);
    ny        = step_axis(py_q, yon[2], yon[3]);
    catch_hit = move_en && (nx == tx_q) && (ny == ty_q);
    rx        = lfsr_q[GRID_LOG2-1:0];
    ry        = lfsr_q[2*GRID_LOG2-1:GRID_LOG2];
    // Never respawn on top of the player
    if ((rx == nx) && (ry == ny)) rx[0] = ~rx[0];
    cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    win_hit   = (cnt_inc == WinCount);
    timer_inc = {1'b0, timer_q} + 17'd1;
    timeout   = play_en && (timer_inc == TimeLimit);
    lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  end

  // Datapath next-state: everything holds unless moving or playing
  always_comb begin
    px_d    = px_q;
    py_d    = py_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    lfsr_d  = lfsr_q;
    if (move_en) begin
      px_d = nx;
      py_d = ny;
    end
    if (catch_hit) begin
      cnt_d   = cnt_inc;
      tx_d    = rx;
      ty_d    = ry;
      timer_d = '0;
    end else if (play_en) begin
      timer_d = timer_inc[15:0];
    end
    if (play_en) begin
      lfsr_d = {lfsr_q[6:0], lfsr_fb};
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_q    <= '0;
      py_q    <= '0;
      tx_q    <= CoordMax;
      ty_q    <= CoordMax;
      cnt_q   <= '0;
      timer_q <= '0;
      lfsr_q  <= LfsrSeed;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    durum           = state_q;
    yakalama_sayisi = cnt_q;
    oyuncu_x        = px_q;
    oyuncu_y        = py_q;
    hedef_x         = tx_q;
    hedef_y         = ty_q;
  end

endmodule

// File: tb/tb_catch_grid.sv
// Directed bench for catch_grid on the default 4x4 grid, 4-bit counter, 15 wins, 16-cycle limit.
module tb_catch_grid;

`ifdef CATCH_GRID_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] yon = 4'b0000;
  logic [1:0] durum;
  logic [3:0] yakalama_sayisi;
  logic [1:0] oyuncu_x, oyuncu_y, hedef_x, hedef_y;

  int checks = 0;
  int errors = 0;

  // Chase model state
  logic [7:0] ml;
  logic [3:0] mv;
  logic [1:0] rx, ry;
  int         mx, my, mtx, mty, mcnt, nx, ny;
  bit         mplay;

  catch_grid #(
    .GRID_LOG2  (2),
    .CNT_W      (4),
    .WIN_CATCHES(15),
    .MOVE_LIMIT (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .yon            (yon),
    .durum          (durum),
    .yakalama_sayisi(yakalama_sayisi),
    .oyuncu_x       (oyuncu_x),
    .oyuncu_y       (oyuncu_y),
    .hedef_x        (hedef_x),
    .hedef_y        (hedef_y)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] v);
    yon = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    yon = 4'b0000;
    rst = 1'b0;
    #7;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_durum", 32'(durum), 0);
    check_eq("rst_cnt", 32'(yakalama_sayisi), 0);
    check_eq("rst_px", 32'(oyuncu_x), 0);
    check_eq("rst_py", 32'(oyuncu_y), 0);
    check_eq("rst_tx", 32'(hedef_x), 3);
    check_eq("rst_ty", 32'(hedef_y), 3);

    // Idle with no direction: nothing moves, LFSR frozen (seen through the later respawn)
    for (int i = 0; i < 5; i++) step(4'b0000);
    check_eq("idle_durum", 32'(durum), 0);
    check_eq("idle_px", 32'(oyuncu_x), 0);
    check_eq("idle_py", 32'(oyuncu_y), 0);

    // Right x3, down x3: catch at (3,3) on edge 6, respawn from LFSR 8'h54 -> (0,1)
    for (int i = 0; i < 3; i++) step(4'b0001);
    check_eq("run_px3", 32'(oyuncu_x), 3);
    check_eq("run_py0", 32'(oyuncu_y), 0);
    check_eq("run_durum", 32'(durum), 1);
    for (int i = 0; i < 3; i++) step(4'b0100);
    check_eq("catch_px", 32'(oyuncu_x), 3);
    check_eq("catch_py", 32'(oyuncu_y), 3);
    check_eq("catch_cnt", 32'(yakalama_sayisi), 1);
    check_eq("catch_durum", 32'(durum), 1);
    check_eq("catch_tx", 32'(hedef_x), 0);
    check_eq("catch_ty", 32'(hedef_y), 1);

    // Asynchronous reset mid-game, checked before any clock edge
    rst = 1'b0;
    #2;
    check_eq("arst_durum", 32'(durum), 0);
    check_eq("arst_cnt", 32'(yakalama_sayisi), 0);
    check_eq("arst_px", 32'(oyuncu_x), 0);
    check_eq("arst_tx", 32'(hedef_x), 3);
    #3;
    rst = 1'b1;
    step(4'b0001);
    check_eq("restart_durum", 32'(durum), 1);
    check_eq("restart_px", 32'(oyuncu_x), 1);

    // Opposing bits, wall behaviour, diagonals
    do_reset();
    step(4'b0101);
    check_eq("diag_px", 32'(oyuncu_x), 1);
    check_eq("diag_py", 32'(oyuncu_y), 1);
    step(4'b1010);
    check_eq("diag_back_px", 32'(oyuncu_x), 0);
    check_eq("diag_back_py", 32'(oyuncu_y), 0);
    step(4'b1010);
    check_eq("wall_px", 32'(oyuncu_x), Wrap ? 3 : 0);
    check_eq("wall_py", 32'(oyuncu_y), Wrap ? 3 : 0);
    step(4'b1100);
    check_eq("updown_py", 32'(oyuncu_y), Wrap ? 3 : 0);
    step(4'b1111);
    check_eq("all_px", 32'(oyuncu_x), Wrap ? 3 : 0);
    check_eq("all_py", 32'(oyuncu_y), Wrap ? 3 : 0);

    // Timeout: enter PLAY with left, then 16 idle PLAY edges
    do_reset();
    step(4'b0010);
    for (int i = 0; i < 15; i++) step(4'b0000);
    check_eq("pre_lose_durum", 32'(durum), 1);
    step(4'b0000);
    check_eq("lose_durum", 32'(durum), 3);
    for (int i = 0; i < 3; i++) step(4'b0101);
    check_eq("lose_hold_durum", 32'(durum), 3);
    check_eq("lose_hold_px", 32'(oyuncu_x), Wrap ? 3 : 0);
    check_eq("lose_hold_py", 32'(oyuncu_y), 0);
    check_eq("lose_cnt", 32'(yakalama_sayisi), 0);

    // Chase to 15 catches against an LFSR model
    do_reset();
    ml = 8'hA5; mx = 0; my = 0; mtx = 3; mty = 3; mcnt = 0; mplay = 1'b0;
    for (int i = 0; i < 400 && mcnt < 15; i++) begin
      mv = 4'b0000;
      if (mtx > mx) mv[0] = 1'b1;
      else if (mtx < mx) mv[1] = 1'b1;
      if (mty > my) mv[2] = 1'b1;
      else if (mty < my) mv[3] = 1'b1;
      nx = mx + (mv[0] ? 1 : 0) - (mv[1] ? 1 : 0);
      ny = my + (mv[2] ? 1 : 0) - (mv[3] ? 1 : 0);
      step(mv);
      if (nx == mtx && ny == mty) begin
        rx = ml[1:0];
        ry = ml[3:2];
        if (int'(rx) == nx && int'(ry) == ny) rx[0] = ~rx[0];
        mtx = int'(rx);
        mty = int'(ry);
        mcnt++;
        check_eq("chase_cnt", 32'(yakalama_sayisi), mcnt);
        check_eq("chase_px", 32'(oyuncu_x), nx);
        check_eq("chase_py", 32'(oyuncu_y), ny);
        check_eq("chase_tx", 32'(hedef_x), mtx);
        check_eq("chase_ty", 32'(hedef_y), mty);
      end
      mx = nx;
      my = ny;
      if (mplay) ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
      mplay = 1'b1;
    end
    check_eq("win_reached", mcnt, 15);
    check_eq("win_durum", 32'(durum), 2);
    check_eq("win_cnt", 32'(yakalama_sayisi), 15);
    for (int i = 0; i < 3; i++) step(4'b0101);
    check_eq("win_hold_durum", 32'(durum), 2);
    check_eq("win_hold_cnt", 32'(yakalama_sayisi), 15);
    check_eq("win_hold_px", 32'(oyuncu_x), mx);
    check_eq("win_hold_py", 32'(oyuncu_y), my);
    check_eq("win_hold_tx", 32'(hedef_x), mtx);

    // Right wall then top wall
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0001);
    check_eq("edge_px", 32'(oyuncu_x), 3);
    step(4'b0001);
    check_eq("rwall_px", 32'(oyuncu_x), Wrap ? 0 : 3);
    check_eq("rwall_py", 32'(oyuncu_y), 0);
    step(4'b1000);
    check_eq("twall_px", 32'(oyuncu_x), Wrap ? 0 : 3);
    check_eq("twall_py", 32'(oyuncu_y), Wrap ? 3 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/catch_grid.md
Name: catch_grid

Overview:
- Parametrised successor of the single-field catch game block: a player token on a 2^GRID_LOG2 x 2^GRID_LOG2 grid, steered by a 4-bit direction input.
- The block tracks a target, counts catches, respawns the target from an internal LFSR and runs a win/lose state machine with a move timeout.
- Sits between the board input synchroniser and the display/score driver; all outputs are registered.

Parameters:
- GRID_LOG2, 2, log2 of grid side; legal range 1..4 (2*GRID_LOG2 <= 8).
- CNT_W, 4, width of catch counter.
- WIN_CATCHES, 15, catch count that ends the game in WIN; must be <= 2^CNT_W-1.
- MOVE_LIMIT, 16, PLAY cycles allowed without a catch before LOSE; range 1..65535.

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- yon  input  4  direction: [3]=up (y-1), [2]=down (y+1), [1]=left (x-1), [0]=right (x+1).
- durum  output  2  game state: 00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.
- yakalama_sayisi  output  CNT_W  catches this game.
- oyuncu_x, oyuncu_y  output  GRID_LOG2 each  player position.
- hedef_x, hedef_y  output  GRID_LOG2 each  target position.

Behaviour:
- Reset (rst=0, async):
  - durum=00, yakalama_sayisi=0, player=(0,0), target=(G-1,G-1) where G=2^GRID_LOG2.
  - LFSR=8'hA5, timer=0.
- IDLE:
  - Holds position.
  - The first edge with yon!=0 goes to PLAY and applies that move on the same edge.
- Move rule, evaluated in PLAY and on the IDLE->PLAY edge:
  - Per axis, opposing bits both set or both clear = no move on that axis.
  - Diagonal moves (one bit per axis) are legal.
  - At a wall the coordinate saturates, with no wrap.
- Catch:
  - Occurs when the next player position equals the current target.
  - Effects on the same edge: yakalama_sayisi+1, timer cleared, target respawns to (lfsr[GRID_LOG2-1:0], lfsr[2*GRID_LOG2-1:GRID_LOG2]) using the pre-advance LFSR value.
  - If the respawn position equals the new player position, the respawn x is inverted in its LSB.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4: new_bit = l[7]^l[5]^l[4]^l[3], shift left with new_bit into bit 0.
  - Advances every clock in PLAY only; frozen in IDLE/WIN/LOSE.
- Timer:
  - Increments each PLAY cycle without a catch.
  - When it would reach MOVE_LIMIT, the next state is LOSE on that edge.
  - A catch on that same edge takes priority: timer clears and the game stays in PLAY.
- WIN:
  - Entered on the edge where the count becomes WIN_CATCHES.
  - WIN has priority over LOSE on the same edge.
- Terminal states (WIN/LOSE):
  - All registers hold and yon is ignored.
  - Only reset exits.
- Counter:
  - Never wraps, because WIN ends the game first.
  - If WIN_CATCHES = 2^CNT_W-1 the counter saturates there.
- Reset mid-game: asynchronously clears all state; the first post-reset edge with yon!=0 restarts the game from IDLE.

Optional Feature:
- CATCH_GRID_WRAP_EN
- Defined: coordinates wrap modulo G at walls (x=G-1 + right -> 0, y=0 + up -> G-1). All other rules are unchanged.
- Undefined: walls saturate as specified above.

Test Plan:
- Reset, then yon=0001 x3 followed by 0100 x3 (4x4 grid) -> player (3,3), catch on the 6th edge, yakalama_sayisi=1, durum=01, target = LFSR model respawn value.
- yon=0000 for 5 cycles after reset -> durum=00, player (0,0), LFSR unchanged at A5.
- yon=1010 at (0,0) -> position stays (0,0); yon=1100 -> no y move; yon=1111 -> no move.
- Enter PLAY with 0010, then hold 0000 for MOVE_LIMIT=16 cycles -> durum=11 on the 16th PLAY edge; further yon ignored; yakalama_sayisi=0.
- Bench LFSR model chases each target until 15 catches -> durum=10, yakalama_sayisi=15, state frozen; pulse rst low mid-game -> immediate durum=00, count=0.
- With CATCH_GRID_WRAP_EN: at (3,0), yon=0001 then 1000 -> (0,0) then (0,3); without the macro -> (3,0) both cycles.
